// File: rtl/viterbi_decoder.sv
// rtl/viterbi_decoder.sv - hard-decision Viterbi decoder for the rate-1/2 K=3 code
//
// Decodes the code p0 = u^a, p1 = u^a^b. The trellis state is {a,b}, with
// index 2*a+b. Survivor paths are kept by register exchange. Each decision is
// taken TB_DEPTH-1 symbols after its data bit, from the survivor of the best
// state. A flush request drains the bits still held in the survivor and then
// reinitialises the decoder.
//
// Ports:
//   clock      single rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   symbol pair present on in_p0/in_p1
//   in_p0      received parity bit p0 (hard decision)
//   in_p1      received parity bit p1 (hard decision)
//   in_ready   symbol accepted this cycle when in_valid is high (RUN state)
//   flush      single-cycle end-of-frame request
//   out_valid  out_bit holds a decoded bit this cycle
//   out_bit    decoded data bit, oldest first
//   busy       high while flushing
module viterbi_decoder #(
  parameter int TB_DEPTH = 16,
  parameter int PM_WIDTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic in_valid,
  input  logic in_p0,
  input  logic in_p1,
  output logic in_ready,
  input  logic flush,
  output logic out_valid,
  output logic out_bit,
  output logic busy
);

  localparam int CW = $clog2(TB_DEPTH + 1);
  localparam int IW = $clog2(TB_DEPTH);
  // Two spare bits: a saturated metric plus a branch metric of 2 must not wrap.
  localparam int MW = PM_WIDTH + 2;
  localparam logic [PM_WIDTH-1:0] PM_MAX = {PM_WIDTH{1'b1}};

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t state, state_nxt;

  logic [PM_WIDTH-1:0] pm       [4];
  logic [PM_WIDTH-1:0] pm_nxt   [4];
  logic [TB_DEPTH-1:0] surv     [4];
  logic [TB_DEPTH-1:0] surv_nxt [4];
  logic [MW-1:0]       raw      [4];
  logic [1:0]          best, best_nxt;
  logic [CW-1:0]       cnt, cnt_inc, cnt_after, pend, pend_init;
  logic [IW-1:0]       fidx;
  logic [MW-1:0]       m0, m1, mn, diff;
  logic                u, a;
  logic                accept, reinit;

  // Hamming distance between the received pair and the pair that the branch
  // from predecessor {a,b} under input u would have produced.
  function automatic logic [1:0] branch_metric(input logic r0, input logic r1,
                                               input logic bu, input logic ba,
                                               input logic bb);
    return {1'b0, r0 ^ bu ^ ba} + {1'b0, r1 ^ bu ^ ba ^ bb};
  endfunction

  assign in_ready = (state == RUN);
  assign busy     = (state == FLUSH);
  assign accept   = in_valid && (state == RUN);
  // The last flush cycle, or the only one when nothing is pending.
  assign reinit   = (state == FLUSH) && (pend <= CW'(1));

  // Add-compare-select. State {u,a} is reached from {a,0} and {a,1}. A tie
  // keeps {a,0}, so the comparison is strict.
  always_comb begin
    u        = 1'b0;
    a        = 1'b0;
    m0       = '0;
    m1       = '0;
    mn       = '0;
    diff     = '0;
    best_nxt = 2'd0;
    for (int s = 0; s < 4; s++) begin
      raw[s]      = '0;
      pm_nxt[s]   = '0;
      surv_nxt[s] = '0;
    end
    for (int s = 0; s < 4; s++) begin
      u  = 1'(s >> 1);
      a  = 1'(s);
      m0 = MW'(pm[{a, 1'b0}]) + MW'(branch_metric(in_p0, in_p1, u, a, 1'b0));
      m1 = MW'(pm[{a, 1'b1}]) + MW'(branch_metric(in_p0, in_p1, u, a, 1'b1));
      if (m1 < m0) begin
        raw[s]      = m1;
        surv_nxt[s] = {surv[{a, 1'b1}][TB_DEPTH-2:0], u};
      end else begin
        raw[s]      = m0;
        surv_nxt[s] = {surv[{a, 1'b0}][TB_DEPTH-2:0], u};
      end
    end
    // The strict compare makes the lowest index win a tie for best state.
    mn = raw[0];
    for (int s = 1; s < 4; s++) begin
      if (raw[s] < mn) begin
        mn       = raw[s];
        best_nxt = 2'(s);
      end
    end
    for (int s = 0; s < 4; s++) begin
      diff      = raw[s] - mn;
      pm_nxt[s] = (diff > MW'(PM_MAX)) ? PM_MAX : diff[PM_WIDTH-1:0];
    end
  end

  always_comb begin
    cnt_inc   = (cnt == CW'(TB_DEPTH)) ? cnt : cnt + 1'b1;
    cnt_after = accept ? cnt_inc : cnt;
    pend_init = (cnt_after > CW'(TB_DEPTH - 1)) ? CW'(TB_DEPTH - 1) : cnt_after;
    fidx      = IW'(pend - 1'b1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (flush) state_nxt = FLUSH;
      FLUSH:   if (pend <= CW'(1)) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Trellis state. It is frozen during FLUSH because nothing is accepted
  // there, so best and surv still hold the entry snapshot.
  always_ff @(posedge clock) begin
    if (reset || reinit) begin
      for (int s = 0; s < 4; s++) begin
        pm[s]   <= (s == 0) ? '0 : PM_MAX;
        surv[s] <= '0;
      end
      cnt  <= '0;
      best <= 2'd0;
    end else if (accept) begin
      pm   <= pm_nxt;
      surv <= surv_nxt;
      cnt  <= cnt_inc;
      best <= best_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      pend      <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept && (cnt >= CW'(TB_DEPTH - 1))) begin
        out_valid <= 1'b1;
        out_bit   <= surv_nxt[best_nxt][TB_DEPTH-1];
      end
      if ((state == RUN) && flush) pend <= pend_init;
      if ((state == FLUSH) && (pend != '0)) begin
        out_valid <= 1'b1;
        out_bit   <= surv[best][fidx];
        pend      <= pend - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
// tb/tb_viterbi_decoder.sv - self-checking bench for viterbi_decoder
module tb_viterbi_decoder;

  localparam int TBD = 16;
  localparam int PMW = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_p0 = 1'b0;
  logic in_p1 = 1'b0;
  logic flush = 1'b0;
  logic in_ready, out_valid, out_bit, busy;

  int checks = 0;
  int errors = 0;

  // Frame-level reference: a clean or lightly corrupted stream decodes back
  // to the data bits. Every frame emits all of its data bits in order.
  bit m_flush = 1'b0;
  int m_rem = 0;
  bit frame[$];
  bit enc_a = 1'b0;
  bit enc_b = 1'b0;

  viterbi_decoder #(.TB_DEPTH(TBD), .PM_WIDTH(PMW)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_p0    (in_p0),
    .in_p1    (in_p1),
    .in_ready (in_ready),
    .flush    (flush),
    .out_valid(out_valid),
    .out_bit  (out_bit),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [PMW-1:0] obs, input logic [PMW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_pm_init();
    chk4("pm0", dut.pm[0], 4'd0);
    chk4("pm1", dut.pm[1], 4'd15);
    chk4("pm2", dut.pm[2], 4'd15);
    chk4("pm3", dut.pm[3], 4'd15);
  endtask

  // One clock. d is the data bit that is encoded on the fly, and err flips
  // the {p0,p1} pair.
  task automatic cycle(input bit v, input bit d, input bit [1:0] err, input bit fl);
    bit acc;
    bit ev;
    bit eb;
    int n;
    acc      = v && !m_flush;
    in_valid = v;
    in_p0    = d ^ enc_a ^ err[1];
    in_p1    = d ^ enc_a ^ enc_b ^ err[0];
    flush    = fl;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    ev = 1'b0;
    eb = 1'b0;
    if (!m_flush) begin
      if (acc) begin
        frame.push_back(d);
        enc_b = enc_a;
        enc_a = d;
        n = frame.size() - 1;
        if (n >= TBD - 1) begin
          ev = 1'b1;
          eb = frame[n - TBD + 1];
        end
      end
      if (fl) begin
        m_flush = 1'b1;
        m_rem   = (frame.size() < TBD - 1) ? frame.size() : TBD - 1;
      end
    end else begin
      if (m_rem > 0) begin
        ev = 1'b1;
        eb = frame[frame.size() - m_rem];
        m_rem--;
      end
      if (m_rem == 0) begin
        m_flush = 1'b0;
        frame.delete();
        enc_a = 1'b0;
        enc_b = 1'b0;
      end
    end
    chk1("out_valid", out_valid, ev);
    if (ev) chk1("out_bit", out_bit, eb);
    chk1("busy", busy, m_flush);
    chk1("in_ready", in_ready, !m_flush);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    @(posedge clock);
    #1;
    reset   = 1'b0;
    m_flush = 1'b0;
    m_rem   = 0;
    frame.delete();
    enc_a = 1'b0;
    enc_b = 1'b0;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_out_bit", out_bit, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
  endtask

  task automatic drain(input bit noisy);
    for (int g = 0; g < 2 * TBD && m_flush; g++)
      cycle(noisy, 1'($urandom_range(0, 1)), 2'b00, noisy && 1'($urandom_range(0, 1)));
  endtask

  initial begin
    bit seq4 [4];
    bit seq5 [5];
    int len;
    int sent;
    bit v;
    seq4 = '{1'b1, 1'b0, 1'b1, 1'b1};
    seq5 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    do_reset();
    check_pm_init();

    // All-zero stream: the first output follows symbol 15.
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 2'b00, 1'b0);
    cycle(1'b0, 1'b0, 2'b00, 1'b1);
    drain(1'b0);

    // Data 1011 then zeros.
    for (int i = 0; i < 20; i++) cycle(1'b1, (i < 4) ? seq4[i] : 1'b0, 2'b00, 1'b0);
    cycle(1'b0, 1'b0, 2'b00, 1'b1);
    drain(1'b0);

    // Same stream with p1 of symbol 2 corrupted.
    for (int i = 0; i < 20; i++)
      cycle(1'b1, (i < 4) ? seq4[i] : 1'b0, (i == 2) ? 2'b01 : 2'b00, 1'b0);
    cycle(1'b0, 1'b0, 2'b00, 1'b1);
    drain(1'b0);

    // Short frame drained entirely by flush.
    for (int i = 0; i < 5; i++) cycle(1'b1, seq5[i], 2'b00, 1'b0);
    cycle(1'b0, 1'b0, 2'b00, 1'b1);
    drain(1'b0);
    check_pm_init();

    // Reset during the third flush cycle.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 2'b00, 1'b0);
    cycle(1'b0, 1'b0, 2'b00, 1'b1);
    cycle(1'b0, 1'b0, 2'b00, 1'b0);
    cycle(1'b0, 1'b0, 2'b00, 1'b0);
    do_reset();
    check_pm_init();
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 2'b00, 1'b0);
    cycle(1'b0, 1'b0, 2'b00, 1'b1);
    drain(1'b0);

    // Flush together with a symbol, then traffic and flush requests while busy.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 2'b00, 1'b0);
    cycle(1'b1, 1'b1, 2'b00, 1'b1);
    drain(1'b1);

    // Random frames with idle gaps, including empty and saturated frames.
    for (int f = 0; f < 30; f++) begin
      len  = $urandom_range(0, 40);
      sent = 0;
      while (sent < len) begin
        v = ($urandom_range(0, 3) != 0);
        cycle(v, 1'($urandom_range(0, 1)), 2'b00, 1'b0);
        if (v) sent++;
      end
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'b00, 1'b1);
      drain(1'($urandom_range(0, 1)));
    end
    check_pm_init();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/viterbi_decoder.md
VITERBI_DECODER -- requirements
Module: viterbi_decoder

Interface
REQ-001 Parameter TB_DEPTH, default 16, is the survivor path length in decoded bits; legal range 4..32.
REQ-002 Parameter PM_WIDTH, default 4, is the path metric width in bits; legal minimum 3.
REQ-003 clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  symbol pair present on in_p0/in_p1.
REQ-006 in_p0  input  1  received parity bit p0 (hard decision).
REQ-007 in_p1  input  1  received parity bit p1 (hard decision).
REQ-008 in_ready  output  1  block accepts a symbol this cycle.
REQ-009 flush  input  1  single-cycle end-of-frame request.
REQ-010 out_valid  output  1  out_bit holds a decoded bit this cycle.
REQ-011 out_bit  output  1  decoded data bit, oldest first.
REQ-012 busy  output  1  high while in the FLUSH state.

Function
REQ-013 The block SHALL decode the rate-1/2, K=3 code of the upstream encoder: for input u with previous inputs a (newest) and b, p0 = u^a and p1 = u^a^b.
REQ-014 The trellis state SHALL be {a,b}, indexed 2*a+b; input u moves state {a,b} to {u,a}.
REQ-015 A symbol SHALL be accepted only when in_valid and in_ready are both high in the same cycle.
REQ-016 The branch metric SHALL be the Hamming distance (0..2) between {in_p0,in_p1} and the branch's expected {p0,p1}.
REQ-017 ACS: each state {u,a} SHALL take min(PM[{a,0}]+BM, PM[{a,1}]+BM); on a tie it SHALL select predecessor {a,0}.
REQ-018 After ACS, the minimum of the four new metrics SHALL be subtracted from all four, and each result SHALL saturate at 2^PM_WIDTH-1.
REQ-019 Survivors SHALL use register exchange: new survivor of {u,a} = the selected predecessor's survivor shifted left by one, with u inserted at bit 0.
REQ-020 Best state SHALL be the state with the minimum metric after the update; on a tie, the lowest index wins.
REQ-021 A symbol counter SHALL saturate at TB_DEPTH.
REQ-022 For accepted symbol n (0-based, counted from reset or flush end) with n >= TB_DEPTH-1, the next cycle SHALL have out_valid=1 and out_bit = bit TB_DEPTH-1 of the best-state survivor, i.e. the decision for data bit n-TB_DEPTH+1.
REQ-023 out_valid SHALL be 0 in every cycle with no accepted symbol in RUN; outputs are registered, with latency one cycle.
REQ-024 The FSM SHALL have two states, RUN and FLUSH; in_ready = 1 in RUN and 0 in FLUSH, and busy = 1 in FLUSH.
REQ-025 RUN->FLUSH on flush=1 in RUN; a symbol accepted in the same cycle SHALL be processed first, and flushing starts the next cycle.
REQ-026 On entering FLUSH, pending = min(symbols accepted, TB_DEPTH-1) and the best state SHALL be frozen.
REQ-027 FLUSH SHALL emit the pending bits one per cycle, oldest first, from the frozen survivor: bit positions pending-1 down to 0.
REQ-028 After the last flush bit, or one cycle after entry when pending=0, the block SHALL reinitialise as at reset and return to RUN.
REQ-029 flush asserted in FLUSH, and in_valid asserted while in_ready=0, SHALL be ignored.

Reset
REQ-030 On reset: PM[0]=0, PM[1..3]=2^PM_WIDTH-1, all survivors 0, counter 0, state RUN, out_valid=0, out_bit=0, busy=0, in_ready=1.
REQ-031 Reset SHALL override everything, including mid-FLUSH; no further flush bits are emitted after it.

Verification
REQ-032 Reset, then 20 symbols {0,0} -> 5 outputs, all 0, the first one cycle after symbol 15.
REQ-033 Data 1,0,1,1 then 16 zeros, encoded as 11,11,10,00,... -> first four outputs 1,0,1,1, then zeros.
REQ-034 Same stream with in_p1 of symbol 2 inverted -> identical output 1,0,1,1,0...
REQ-035 Five symbols of data 1,0,1,1,0 then flush -> busy high for 5 cycles, outputs 1,0,1,1,0, then in_ready=1 and PM back to 0,max,max,max.
REQ-036 Reset asserted during the 3rd flush cycle -> next cycle out_valid=0 and busy=0; a following all-zero stream decodes to 0s.
REQ-037 flush and in_valid in the same cycle, and in_valid pulsed while busy -> that symbol is included in the flush; symbols during busy are dropped.
